// File: rtl/adder_resp_checker_pkg.sv
// adder_chk_pkg: shared definitions for the adder response checker.
//   - state_t         : checker FSM encoding (IDLE / SETTLE / CHECK)
//   - DEF_WIDTH       : default operand width of the adder family
//   - golden_sum()    : reference a+b+ci at DEF_WIDTH+1 bits, carry in the MSB
package adder_chk_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    // Operands are zero-extended so the carry-out lands in the result MSB.
    function automatic logic [DEF_WIDTH:0] golden_sum(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b,
        input logic                 ci
    );
        return {1'b0, a} + {1'b0, b} + {{DEF_WIDTH{1'b0}}, ci};
    endfunction

endpackage

// File: rtl/adder_resp_checker_if.sv
// adder_resp_checker_if: vector-source handshake plus the operand/result
// bus towards the adder under check.
//   in_valid/in_ready/in_a/in_b/in_ci : vector source -> checker
//   drv_a/drv_b/drv_ci                : checker -> adder operands
//   dut_sum/dut_co                    : adder result -> checker
// Modports:
//   master : environment side (vector source and adder)
//   slave  : checker side
interface adder_resp_checker_if #(
    parameter int WIDTH = adder_chk_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic [WIDTH-1:0] drv_a;
    logic [WIDTH-1:0] drv_b;
    logic             drv_ci;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_co;

    modport master (
        output in_valid, in_a, in_b, in_ci, dut_sum, dut_co,
        input  in_ready, drv_a, drv_b, drv_ci
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci, dut_sum, dut_co,
        output in_ready, drv_a, drv_b, drv_ci
    );
endinterface

// File: rtl/adder_resp_checker_golden.sv
// adder_golden: combinational WIDTH-bit reference adder with carry.
//   a, b   : operands
//   ci     : carry-in
//   sum_co : {carry-out, sum}, WIDTH+1 bits
module adder_golden #(
    parameter int WIDTH = adder_chk_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH:0]   sum_co
);
    assign sum_co = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
endmodule

// File: rtl/adder_resp_checker.sv
// adder_resp_checker: accepts operand vectors, drives them onto an adder,
// waits SETTLE_CYC cycles, samples the adder result and compares it with a
// golden a+b+ci. Keeps saturating pass/error counters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave modport) : in_valid/in_ready/in_a/in_b/in_ci handshake,
//                         drv_a/drv_b/drv_ci operands, dut_sum/dut_co result
//   chk_done            : one-cycle pulse when a compare completes
//   chk_err             : one-cycle pulse with chk_done on mismatch
//   pass_cnt, err_cnt   : saturating match / mismatch counters
// Optional: ADDER_RESP_CHECKER_FIRST_FAIL_EN adds ff_valid, ff_vec ({a,b,ci})
//   and ff_got ({co,sum}) holding the first mismatch after reset.
module adder_resp_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = 3,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_resp_checker_if.slave  bus,
    output logic                 chk_done,
    output logic                 chk_err,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     err_cnt
`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
    ,
    output logic                 ff_valid,
    output logic [2*WIDTH:0]     ff_vec,
    output logic [WIDTH:0]       ff_got
`endif
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_t           state_reg, state_next;
    logic             in_ready_reg, in_ready_next;
    logic [7:0]       settle_cnt_reg;
    logic [WIDTH-1:0] drv_a_reg, drv_b_reg;
    logic             drv_ci_reg;
    logic [WIDTH:0]   gold_w, gold_reg, sample_reg;
    logic             chk_done_reg, chk_err_reg;
    logic             accept, sample_en, check_en, mismatch;
    logic [1:0]       cnt_inc;

    adder_golden #(.WIDTH(WIDTH)) u_golden (
        .a      (bus.in_a),
        .b      (bus.in_b),
        .ci     (bus.in_ci),
        .sum_co (gold_w)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (bus.in_valid) state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt_reg == 8'd0) state_next = ST_CHECK;
            ST_CHECK:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept    = 1'b0;
        sample_en = 1'b0;
        check_en  = 1'b0;
        case (state_reg)
            ST_IDLE:   accept    = bus.in_valid;
            ST_SETTLE: sample_en = (settle_cnt_reg == 8'd0);
            ST_CHECK:  check_en  = 1'b1;
            default:   ;
        endcase
        // Registered so in_ready never depends combinationally on in_valid.
        in_ready_next = (state_next == ST_IDLE);
    end

    // X/Z on the adder result must count as a mismatch in simulation.
    assign mismatch = (sample_reg !== gold_reg);
    assign cnt_inc  = {check_en & mismatch, check_en & ~mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_reg   <= 1'b1;
            settle_cnt_reg <= 8'd0;
            drv_a_reg      <= '0;
            drv_b_reg      <= '0;
            drv_ci_reg     <= 1'b0;
            gold_reg       <= '0;
            sample_reg     <= '0;
            chk_done_reg   <= 1'b0;
            chk_err_reg    <= 1'b0;
        end else begin
            in_ready_reg <= in_ready_next;
            chk_done_reg <= check_en;
            chk_err_reg  <= check_en & mismatch;
            if (accept) begin
                drv_a_reg      <= bus.in_a;
                drv_b_reg      <= bus.in_b;
                drv_ci_reg     <= bus.in_ci;
                gold_reg       <= gold_w;
                settle_cnt_reg <= SETTLE_LOAD;
            end else if (state_reg == ST_SETTLE && settle_cnt_reg != 8'd0) begin
                settle_cnt_reg <= settle_cnt_reg - 8'd1;
            end
            // Captured on the last SETTLE edge: operands have then been
            // stable for exactly SETTLE_CYC cycles.
            if (sample_en) begin
                sample_reg <= {bus.dut_co, bus.dut_sum};
            end
        end
    end

    // Saturating counters: index 0 = pass, index 1 = error.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign pass_cnt     = g_cnt[0].cnt_reg;
    assign err_cnt      = g_cnt[1].cnt_reg;
    assign chk_done     = chk_done_reg;
    assign chk_err      = chk_err_reg;
    assign bus.in_ready = in_ready_reg;
    assign bus.drv_a    = drv_a_reg;
    assign bus.drv_b    = drv_b_reg;
    assign bus.drv_ci   = drv_ci_reg;

`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
    logic             ff_valid_reg;
    logic [2*WIDTH:0] ff_vec_reg;
    logic [WIDTH:0]   ff_got_reg;

    // Only the first mismatch after reset is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid_reg <= 1'b0;
            ff_vec_reg   <= '0;
            ff_got_reg   <= '0;
        end else if (check_en && mismatch && !ff_valid_reg) begin
            ff_valid_reg <= 1'b1;
            ff_vec_reg   <= {drv_a_reg, drv_b_reg, drv_ci_reg};
            ff_got_reg   <= sample_reg;
        end
    end

    assign ff_valid = ff_valid_reg;
    assign ff_vec   = ff_vec_reg;
    assign ff_got   = ff_got_reg;
`endif

endmodule

// File: tb/tb_adder_resp_checker.sv
// Testbench for adder_resp_checker: ideal adder on the main instance, a
// two-register delay adder on instances with SETTLE_CYC=1 and 4.
module tb_adder_resp_checker;

    localparam int S = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- main instance (ideal adder) ----------------
    adder_resp_checker_if #(.WIDTH(4)) m_if ();
    logic       chk_done, chk_err;
    logic [7:0] pass_cnt, err_cnt;
    logic       src_valid, src_ci, force_co0;
    logic [3:0] src_a, src_b;
    logic [4:0] m_full;

    assign m_if.in_valid = src_valid;
    assign m_if.in_a     = src_a;
    assign m_if.in_b     = src_b;
    assign m_if.in_ci    = src_ci;
    assign m_full        = 5'(m_if.drv_a) + 5'(m_if.drv_b) + 5'(m_if.drv_ci);
    assign m_if.dut_sum  = m_full[3:0];
    assign m_if.dut_co   = m_full[4] & ~force_co0;

`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
    logic ff_valid, s1_ffv, s4_ffv;
    logic [8:0] ff_vec, s1_ffvec, s4_ffvec;
    logic [4:0] ff_got, s1_ffgot, s4_ffgot;
`endif

    adder_resp_checker #(.WIDTH(4), .SETTLE_CYC(S), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(m_if),
        .chk_done(chk_done), .chk_err(chk_err),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt)
`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
        , .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_got(ff_got)
`endif
    );

    // ---------------- delay-adder instances ----------------
    adder_resp_checker_if #(.WIDTH(4)) s1_if ();
    adder_resp_checker_if #(.WIDTH(4)) s4_if ();
    logic       s1_done, s1_err, s4_done, s4_err;
    logic [7:0] s1_pass, s1_errc, s4_pass, s4_errc;
    logic       p_valid, p_ci;
    logic [3:0] p_a, p_b;
    logic [4:0] s1_d1, s1_d2, s4_d1, s4_d2;

    assign s1_if.in_valid = p_valid;
    assign s1_if.in_a     = p_a;
    assign s1_if.in_b     = p_b;
    assign s1_if.in_ci    = p_ci;
    assign s4_if.in_valid = p_valid;
    assign s4_if.in_a     = p_a;
    assign s4_if.in_b     = p_b;
    assign s4_if.in_ci    = p_ci;

    // Result appears two clocks after the operands change.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_d1 <= 5'd0; s1_d2 <= 5'd0; s4_d1 <= 5'd0; s4_d2 <= 5'd0;
        end else begin
            s1_d1 <= 5'(s1_if.drv_a) + 5'(s1_if.drv_b) + 5'(s1_if.drv_ci);
            s1_d2 <= s1_d1;
            s4_d1 <= 5'(s4_if.drv_a) + 5'(s4_if.drv_b) + 5'(s4_if.drv_ci);
            s4_d2 <= s4_d1;
        end
    end
    assign s1_if.dut_sum = s1_d2[3:0];
    assign s1_if.dut_co  = s1_d2[4];
    assign s4_if.dut_sum = s4_d2[3:0];
    assign s4_if.dut_co  = s4_d2[4];

    adder_resp_checker #(.WIDTH(4), .SETTLE_CYC(1), .CNT_W(8)) u_s1 (
        .clk(clk), .rst_n(rst_n), .bus(s1_if),
        .chk_done(s1_done), .chk_err(s1_err),
        .pass_cnt(s1_pass), .err_cnt(s1_errc)
`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
        , .ff_valid(s1_ffv), .ff_vec(s1_ffvec), .ff_got(s1_ffgot)
`endif
    );

    adder_resp_checker #(.WIDTH(4), .SETTLE_CYC(4), .CNT_W(8)) u_s4 (
        .clk(clk), .rst_n(rst_n), .bus(s4_if),
        .chk_done(s4_done), .chk_err(s4_err),
        .pass_cnt(s4_pass), .err_cnt(s4_errc)
`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
        , .ff_valid(s4_ffv), .ff_vec(s4_ffvec), .ff_got(s4_ffgot)
`endif
    );

    // ---------------- behavioural model + per-cycle compare ----------------
    // A vector accepted in cycle n is sampled in cycle n+S and reported in
    // cycle n+S+2; the checker is busy in between.
    int         cyc = 0;
    logic       m_pend = 1'b0;
    int         m_samp, m_due;
    logic [4:0] m_gold = 5'd0, m_got = 5'd0;
    logic [8:0] e_vec = 9'd0;
    int         e_pass = 0, e_err = 0;
    logic       e_ready, e_done, e_cerr;
    int         acc_cyc[$];
    int         done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_pend = 1'b0; e_vec = 9'd0; e_pass = 0; e_err = 0;
            check("rst_in_ready", m_if.in_ready, 1);
            check("rst_chk_done", chk_done, 0);
            check("rst_chk_err", chk_err, 0);
            check("rst_pass_cnt", pass_cnt, 0);
            check("rst_err_cnt", err_cnt, 0);
            check("rst_drv", {m_if.drv_a, m_if.drv_b, m_if.drv_ci}, 0);
        end else begin
            e_done = 1'b0;
            e_cerr = 1'b0;
            if (m_pend && cyc == m_samp) m_got = {m_if.dut_co, m_if.dut_sum};
            if (m_pend && cyc == m_due) begin
                e_done = 1'b1;
                e_cerr = (m_got != m_gold);
                if (e_cerr) e_err = (e_err < 255) ? e_err + 1 : 255;
                else        e_pass = (e_pass < 255) ? e_pass + 1 : 255;
                m_pend = 1'b0;
            end
            e_ready = !m_pend;
            check("in_ready", m_if.in_ready, e_ready);
            check("chk_done", chk_done, e_done);
            check("chk_err", chk_err, e_cerr);
            check("pass_cnt", pass_cnt, e_pass);
            check("err_cnt", err_cnt, e_err);
            check("drv", {m_if.drv_a, m_if.drv_b, m_if.drv_ci}, e_vec);
            if (chk_done) done_cyc = cyc;
            if (src_valid && e_ready) begin
                m_pend = 1'b1;
                m_samp = cyc + S;
                m_due  = cyc + S + 2;
                m_gold = 5'(src_a) + 5'(src_b) + 5'(src_ci);
                e_vec  = {src_a, src_b, src_ci};
                acc_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic ci);
        bit ok = 1'b0;
        @(posedge clk); #1;
        src_valid = 1'b1; src_a = a; src_b = b; src_ci = ci;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (m_if.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            bad++; total++;
            $display("FAIL send_timeout: got=no_accept expected=accept");
        end
        @(posedge clk); #1;
        src_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (chk_done) ok = 1'b1;
        end
        if (!ok) begin
            bad++; total++;
            $display("FAIL done_timeout: got=no_chk_done expected=chk_done");
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n0;
        bit d1, d4;
        logic [7:0] v;
        src_valid = 1'b0; src_a = 4'd0; src_b = 4'd0; src_ci = 1'b0; force_co0 = 1'b0;
        p_valid = 1'b0; p_a = 4'd0; p_b = 4'd0; p_ci = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // A + 3 + 0 = 0D
        send(4'hA, 4'h3, 1'b0);
        wait_done();
        check("lat_A3", done_cyc - acc_cyc[$], 5);
        check("gold_A3", m_gold, 5'h0D);
        check("err_A3", chk_err, 0);
        check("pass_A3", pass_cnt, 8'd1);
        $display("vec a=A b=3 ci=0 done=%0b err=%0b pass=%0d", chk_done, chk_err, pass_cnt);

        // F + F + 1 = 1F
        send(4'hF, 4'hF, 1'b1);
        wait_done();
        check("gold_FF1", m_gold, 5'h1F);
        check("err_FF1", chk_err, 0);
        check("pass_FF1", pass_cnt, 8'd2);
        $display("vec a=F b=F ci=1 done=%0b err=%0b pass=%0d", chk_done, chk_err, pass_cnt);

        // same vector with carry-out stuck at 0
        force_co0 = 1'b1;
        send(4'hF, 4'hF, 1'b1);
        wait_done();
        check("err_forced", chk_err, 1);
        check("errcnt_forced", err_cnt, 8'd1);
`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
        check("ff_valid", ff_valid, 1);
        check("ff_vec", ff_vec, 9'h1FF);
        check("ff_got", ff_got, 5'h0F);
`endif
        $display("vec a=F b=F ci=1 co0 done=%0b err=%0b errcnt=%0d", chk_done, chk_err, err_cnt);
        force_co0 = 1'b0;

        // in_valid held high: one accept every S+2 cycles
        n0 = acc_cyc.size();
        @(posedge clk); #1;
        src_valid = 1'b1; src_a = 4'h2; src_b = 4'hF; src_ci = 1'b0;
        repeat (17) @(posedge clk);
        #1 src_valid = 1'b0;
        check("hold_accepts", acc_cyc.size() - n0, 4);
        for (int i = n0 + 1; i < acc_cyc.size(); i++)
            check("hold_period", acc_cyc[i] - acc_cyc[i-1], 5);
        wait_done();
        check("hold_pass", pass_cnt, 8'd6);
        check("hold_err", err_cnt, 8'd1);
        $display("vec a=2 b=F ci=0 held accepts=%0d pass=%0d", acc_cyc.size() - n0, pass_cnt);

        // asynchronous reset in the middle of SETTLE
        send(4'h1, 4'h1, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", m_if.in_ready, 1);
        check("arst_done", chk_done, 0);
        check("arst_pass", pass_cnt, 0);
        check("arst_err", err_cnt, 0);
        check("arst_drv", {m_if.drv_a, m_if.drv_b, m_if.drv_ci}, 0);
`ifdef ADDER_RESP_CHECKER_FIRST_FAIL_EN
        check("arst_ff", {ff_valid, ff_vec, ff_got}, 0);
`endif
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("arst_after_pass", pass_cnt, 0);
        $display("reset mid-settle in_ready=%0b pass=%0d err=%0d", m_if.in_ready, pass_cnt, err_cnt);

        // 260 passing vectors: pass counter saturates
        for (int i = 0; i < 260; i++) begin
            v = 8'(i);
            send(v[3:0], v[7:4], v[0]);
        end
        wait_done();
        check("sat_pass", pass_cnt, 8'hFF);
        check("sat_err", err_cnt, 8'd0);
        $display("260 vectors pass=%0h err=%0h", pass_cnt, err_cnt);

        // delay adder: 5 + 6 + 0 fails with one settle cycle, passes with four
        @(posedge clk); #1;
        p_valid = 1'b1; p_a = 4'h5; p_b = 4'h6; p_ci = 1'b0;
        @(posedge clk); #1 p_valid = 1'b0;
        d1 = 1'b0; d4 = 1'b0;
        for (int i = 0; i < 20 && !(d1 && d4); i++) begin
            @(negedge clk);
            if (s1_done) d1 = 1'b1;
            if (s4_done) d4 = 1'b1;
        end
        check("s1_seen", d1, 1);
        check("s4_seen", d4, 1);
        check("s1_err", s1_errc, 8'd1);
        check("s1_pass", s1_pass, 8'd0);
        check("s4_pass", s4_pass, 8'd1);
        check("s4_err", s4_errc, 8'd0);
        $display("delay adder s1 err=%0d s4 pass=%0d", s1_errc, s4_pass);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_resp_checker.md
Name: adder_resp_checker

Overview:
- Synthesizable response-side companion for the 4-bit ripple/delay adder family (adder_t* variants).
- Accepts operand vectors over a valid/ready handshake and drives them onto the DUT operand bus.
- Waits a fixed settle window, samples the DUT sum/carry and compares against a golden a+b+ci.
- Keeps pass/error counts; sits between a vector source and any adder_t* instance in hardware or in a bench.

Parameters:
- WIDTH, 4, operand and sum width.
- SETTLE_CYC, 3, clock cycles between driving operands and sampling DUT outputs; legal range 1..255.
- CNT_W, 8, width of the pass and error counters.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  vector-source valid.
- in_ready  out  1  checker can accept a vector.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_ci  in  1  carry-in.
- drv_a  out  WIDTH  operand a to DUT, registered.
- drv_b  out  WIDTH  operand b to DUT, registered.
- drv_ci  out  1  carry-in to DUT, registered.
- dut_sum  in  WIDTH  DUT sum.
- dut_co  in  1  DUT carry-out.
- chk_done  out  1  one-cycle pulse: a compare completed.
- chk_err  out  1  one-cycle pulse, coincident with chk_done: mismatch.
- pass_cnt  out  CNT_W  matching vectors, saturating.
- err_cnt  out  CNT_W  mismatching vectors, saturating.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE; in_ready 1; drv_a, drv_b, drv_ci 0; chk_done and chk_err 0; both counters 0; settle counter 0.
- FSM: IDLE -> SETTLE -> CHECK -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_a, in_b, in_ci into drv_* and into a golden register {co,sum} = in_a+in_b+in_ci, computed at WIDTH+1 bits.
  - Load settle counter with SETTLE_CYC-1; go to SETTLE.
- SETTLE:
  - in_ready=0; drv_* held stable.
  - Counter decrements each cycle; at 0 go to CHECK.
  - Result: the DUT sees stable operands for exactly SETTLE_CYC cycles before sampling.
- CHECK:
  - Sample {dut_co,dut_sum} and compare with the golden value.
  - Next cycle: chk_done=1; chk_err=1 if any bit differs, including X/Z in simulation, treated as mismatch via a !== compare.
  - Increment err_cnt or pass_cnt; return to IDLE.
- Throughput: one vector per SETTLE_CYC+2 cycles. Latency from accept to chk_done is SETTLE_CYC+2 cycles.
- in_ready is a registered state decode; it does not depend combinationally on in_valid.
- in_valid while busy is ignored. The source must hold its vector until accepted.
- Counters saturate at all-ones; no wrap.
- Golden arithmetic: zero-extend operands to WIDTH+1 bits; carry-out is the MSB of the result.
- drv_* keep the last vector after CHECK, until the next accept.
- Reset mid-vector: abort immediately, no chk_done pulse, counters cleared, drv_* cleared.
- Accept in the same cycle that CHECK returns to IDLE: not possible. in_ready rises the cycle after CHECK.

Optional Feature:
- Macro: ADDER_RESP_CHECKER_FIRST_FAIL_EN.
- Defined:
  - Adds outputs ff_valid (1), ff_vec (2*WIDTH+1 bits = {a,b,ci}) and ff_got (WIDTH+1 bits = {co,sum}).
  - On the first mismatch after reset, capture the vector and the DUT result and set ff_valid.
  - Later mismatches do not overwrite the capture. All three outputs reset to 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package adder_chk_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_CHECK=2'd2;
  - default WIDTH;
  - a golden-sum function returning WIDTH+1 bits.
- One sub-module: adder_golden (combinational WIDTH-bit reference adder with carry), instanced once for the golden value.
- FSM and counters stay in the top module.

Test Plan:
- Reset, then vector a=4'hA, b=4'h3, ci=0 against adder_t1:
  - chk_done exactly SETTLE_CYC+2 cycles after accept;
  - chk_err=0; pass_cnt=1.
- a=4'hF, b=4'hF, ci=1:
  - golden {co,sum}=5'h1F; DUT matches; chk_err=0.
  - Force dut_co=0: chk_err=1, err_cnt=1; with the macro defined, ff_vec={F,F,1} and ff_got=5'h0F.
- Hold in_valid high continuously with vectors 2,F,0:
  - exactly one accept per SETTLE_CYC+2 cycles;
  - in_ready low throughout SETTLE and CHECK;
  - drv_* stable during SETTLE.
- SETTLE_CYC=1 versus a delay-model adder whose settle time exceeds one clock:
  - mismatch reported (err_cnt increments);
  - with SETTLE_CYC=4 the same vector passes.
- Assert rst_n low mid-SETTLE:
  - all outputs return to reset values asynchronously;
  - no chk_done pulse; in_ready=1 after release.
- Drive 260 passing vectors with CNT_W=8: pass_cnt saturates at 8'hFF and err_cnt stays 0.
